// File: rtl/phy_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_fifo_pkg
// Purpose  : Shared PHY constants (idle word, word width, FIFO depth) used by
//            the PHY transmit and receive paths, plus small helpers.
// Revision : 1.0 - initial release
// ============================================================================
package phy_rx_fifo_pkg;

    // Default PHY word width and receive FIFO depth shared by phy_tx / phy_rx
    localparam int PHY_DATA_W     = 32;
    localparam int PHY_FIFO_DEPTH = 8;

    // Line idle pattern; never stored in the receive FIFO
    localparam logic [31:0] IDLE_WORD = 32'hBCBCBCBC;

    // Saturation limit for the dropped-word counter
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Saturating increment for an 8-bit event counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == ERR_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage : phy_rx_fifo_pkg
`default_nettype wire

// File: rtl/phy_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : phy_fifo_mem
// Purpose  : DEPTH x DATA_W storage array for the PHY receive FIFO.
//            Synchronous write, asynchronous (combinational) read. The array
//            is not reset; contents are only meaningful where the FIFO
//            control logic says a word is valid.
// Revision : 1.0 - initial release
// ============================================================================
module phy_fifo_mem
    import phy_rx_fifo_pkg::*;
#(
    parameter int DATA_W = PHY_DATA_W,
    parameter int DEPTH  = PHY_FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Store the incoming word at the write address on an accepted push
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Head word is visible combinationally so the pop can register it directly
    assign rd_data = r_mem[rd_addr];

endmodule : phy_fifo_mem
`default_nettype wire

// File: rtl/phy_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_fifo
// Purpose  : Single-clock receive FIFO between the PHY receiver and the link
//            layer. Idle words are discarded, words arriving while full (with
//            no simultaneous pop) are dropped and flagged by a sticky
//            overflow bit. Popped words are registered onto data_out.
// Options  : PHY_RX_FIFO_ERR_CNT_EN - adds the 8-bit saturating err_count
//            port counting dropped words.
// Revision : 1.0 - initial release
// ============================================================================
module phy_rx_fifo
    import phy_rx_fifo_pkg::*;
#(
    parameter int DATA_W    = PHY_DATA_W,
    parameter int DEPTH     = PHY_FIFO_DEPTH,   // power of two, at least 4
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow
`ifdef PHY_RX_FIFO_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;   // one extra bit so a full FIFO is representable

    localparam logic [CW-1:0]     C_DEPTH     = CW'(DEPTH);
    localparam logic [CW-1:0]     C_AF_THRESH = CW'(AF_THRESH);
    localparam logic [CW-1:0]     C_AE_THRESH = CW'(AE_THRESH);
    localparam logic [DATA_W-1:0] C_IDLE      = DATA_W'(IDLE_WORD);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;
    logic              r_overflow;

    logic              w_word_ok;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_head;

    // ------------------------------------------------------------------
    // Occupancy flags, purely from the registered count
    // ------------------------------------------------------------------
    assign full         = (r_count == C_DEPTH);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= C_AF_THRESH);
    assign almost_empty = (r_count <= C_AE_THRESH);

    // ------------------------------------------------------------------
    // Push / pop / drop decisions
    // A pop is only honoured with data present; a push into a full FIFO
    // is accepted only when the same edge frees a slot by popping.
    // ------------------------------------------------------------------
    assign w_word_ok = valid_in && (data_in != C_IDLE);
    assign w_pop     = rd_en && !empty;
    assign w_push    = w_word_ok && (!full || w_pop);
    assign w_drop    = w_word_ok && full && !w_pop;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    phy_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk_f),
        .wr_en   (w_push && !reset),
        .wr_addr (r_wr_ptr),
        .wr_data (data_in),
        .rd_addr (r_rd_ptr),
        .rd_data (w_head)
    );

    // Advance wrapping pointers and track occupancy
    always_ff @(posedge clk_f) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Register the head word on a pop; valid_out marks only popping cycles
    always_ff @(posedge clk_f) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_pop;
            if (w_pop) begin
                r_data_out <= w_head;
            end
        end
    end

    // Sticky record that a real word was lost to a full FIFO
    always_ff @(posedge clk_f) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign overflow  = r_overflow;

`ifdef PHY_RX_FIFO_ERR_CNT_EN
    logic [7:0] r_err_count;

    // Count dropped words, holding at the maximum rather than wrapping
    always_ff @(posedge clk_f) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_drop) begin
            r_err_count <= sat_inc8(r_err_count);
        end
    end

    assign err_count = r_err_count;
`endif

endmodule : phy_rx_fifo
`default_nettype wire

// File: tb/tb_phy_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_rx_fifo
// Purpose  : Directed self-checking bench for phy_rx_fifo (default params).
// Options  : PHY_RX_FIFO_ERR_CNT_EN - also connects and checks err_count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_rx_fifo;

    logic        clk_f;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        rd_en;
    logic [31:0] data_out;
    logic        valid_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
`ifdef PHY_RX_FIFO_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    phy_rx_fifo dut (
        .clk_f        (clk_f),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow)
`ifdef PHY_RX_FIFO_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    // Advance one edge, then settle before looking at outputs
    task automatic step();
        @(posedge clk_f);
        #1;
    endtask

    // Expected {full, empty, almost_full, almost_empty} for DEPTH=8, AF=6, AE=2
    function automatic logic [3:0] exp_flags(input int occ);
        logic [3:0] f;
        f[3] = (occ == 8);
        f[2] = (occ == 0);
        f[1] = (occ >= 6);
        f[0] = (occ <= 2);
        return f;
    endfunction

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; rd_en = 1'b0; data_in = '0;
        step();
        step();
        n_cmp++;
        if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", {full, empty, almost_full, almost_empty}, 4'b0101);
        end
        n_cmp++;
        if ({valid_out, overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_valid_ovf: got %b expected %b", {valid_out, overflow}, 2'b00);
        end
        n_cmp++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected %h", data_out, 32'h0);
        end
`ifdef PHY_RX_FIFO_ERR_CNT_EN
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_errcnt: got %0d expected 0", err_count);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 3; i++) begin
            valid_in = 1'b1; data_in = 32'(i); rd_en = 1'b0;
            step();
            n_cmp++;
            if ({full, empty, almost_full, almost_empty} !== exp_flags(i)) begin
                n_fail++;
                $display("FAIL basic_wr_flags[%0d]: got %b expected %b", i, {full, empty, almost_full, almost_empty}, exp_flags(i));
            end
        end
        valid_in = 1'b0; rd_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if ({valid_out, data_out} !== {1'b1, 32'(i)}) begin
                n_fail++;
                $display("FAIL basic_rd[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, valid_out, data_out, 32'(i));
            end
        end
        rd_en = 1'b0;
        step();
        n_cmp++;
        if ({valid_out, data_out} !== {1'b0, 32'h3}) begin
            n_fail++;
            $display("FAIL basic_idle_out: got valid=%b data=%h expected valid=0 data=3", valid_out, data_out);
        end
        n_cmp++;
        if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
            n_fail++;
            $display("FAIL basic_end_flags: got %b expected 0101", {full, empty, almost_full, almost_empty});
        end
    endtask

    task automatic test_empty_read();
        valid_in = 1'b1; data_in = 32'h77; rd_en = 1'b1;
        step();
        n_cmp++;
        if ({valid_out, data_out} !== {1'b0, 32'h3}) begin
            n_fail++;
            $display("FAIL emptyrd_nopop: got valid=%b data=%h expected valid=0 data=3", valid_out, data_out);
        end
        n_cmp++;
        if ({full, empty, almost_full, almost_empty} !== 4'b0001) begin
            n_fail++;
            $display("FAIL emptyrd_flags: got %b expected 0001", {full, empty, almost_full, almost_empty});
        end
        valid_in = 1'b0;
        step();
        n_cmp++;
        if ({valid_out, data_out} !== {1'b1, 32'h77}) begin
            n_fail++;
            $display("FAIL emptyrd_pop: got valid=%b data=%h expected valid=1 data=77", valid_out, data_out);
        end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_idle();
        valid_in = 1'b1; data_in = 32'hBCBCBCBC; rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({full, empty, almost_full, almost_empty, overflow} !== 5'b01010) begin
                n_fail++;
                $display("FAIL idle[%0d]: got flags/ovf %b expected 01010", i, {full, empty, almost_full, almost_empty, overflow});
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_overflow();
        rd_en = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            valid_in = 1'b1; data_in = 32'(i);
            step();
            n_cmp++;
            if ({full, empty, almost_full, almost_empty} !== exp_flags(i > 8 ? 8 : i)) begin
                n_fail++;
                $display("FAIL ovf_flags[%0d]: got %b expected %b", i, {full, empty, almost_full, almost_empty}, exp_flags(i > 8 ? 8 : i));
            end
            n_cmp++;
            if (overflow !== (i == 9)) begin
                n_fail++;
                $display("FAIL ovf_bit[%0d]: got %b expected %b", i, overflow, (i == 9));
            end
        end
`ifdef PHY_RX_FIFO_ERR_CNT_EN
        n_cmp++;
        if (err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL ovf_errcnt: got %0d expected 1", err_count);
        end
`endif
        // Idle word while full is silently discarded, not counted as a drop
        data_in = 32'hBCBCBCBC;
        step();
`ifdef PHY_RX_FIFO_ERR_CNT_EN
        n_cmp++;
        if (err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL ovf_idle_errcnt: got %0d expected 1", err_count);
        end
`endif
        n_cmp++;
        if ({full, overflow} !== 2'b11) begin
            n_fail++;
            $display("FAIL ovf_idle_full: got %b expected 11", {full, overflow});
        end
        valid_in = 1'b0; rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++;
            if ({valid_out, data_out} !== {1'b1, 32'(i)}) begin
                n_fail++;
                $display("FAIL ovf_rd[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, valid_out, data_out, 32'(i));
            end
        end
        rd_en = 1'b0;
        step();
        n_cmp++;
        if ({empty, overflow, valid_out} !== 3'b110) begin
            n_fail++;
            $display("FAIL ovf_drained: got empty/ovf/valid %b expected 110", {empty, overflow, valid_out});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_reset_clear: got %b expected 0", overflow);
        end
`ifdef PHY_RX_FIFO_ERR_CNT_EN
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL ovf_reset_errcnt: got %0d expected 0", err_count);
        end
`endif
    endtask

    task automatic test_full_simul();
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1; data_in = 32'h10 + 32'(i);
            step();
        end
        n_cmp++;
        if ({full, empty, almost_full, almost_empty} !== 4'b1010) begin
            n_fail++;
            $display("FAIL fullsim_fill: got %b expected 1010", {full, empty, almost_full, almost_empty});
        end
        data_in = 32'hA5A5A5A5; rd_en = 1'b1;
        step();
        n_cmp++;
        if ({full, overflow, valid_out} !== 3'b101) begin
            n_fail++;
            $display("FAIL fullsim_flags: got full/ovf/valid %b expected 101", {full, overflow, valid_out});
        end
        n_cmp++;
        if (data_out !== 32'h10) begin
            n_fail++;
            $display("FAIL fullsim_first: got %h expected 00000010", data_out);
        end
        valid_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if ({valid_out, data_out} !== {1'b1, (k == 8) ? 32'hA5A5A5A5 : 32'h10 + 32'(k)}) begin
                n_fail++;
                $display("FAIL fullsim_rd[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, valid_out, data_out, (k == 8) ? 32'hA5A5A5A5 : 32'h10 + 32'(k));
            end
        end
        rd_en = 1'b0;
        step();
        n_cmp++;
        if ({full, empty, almost_full, almost_empty, overflow} !== 5'b01010) begin
            n_fail++;
            $display("FAIL fullsim_end: got %b expected 01010", {full, empty, almost_full, almost_empty, overflow});
        end
    endtask

    task automatic test_reset_mid();
        valid_in = 1'b1; rd_en = 1'b0;
        data_in = 32'h21; step();
        data_in = 32'h22; step();
        rd_en = 1'b1;
        data_in = 32'h23; step();
        data_in = 32'h24; step();
        n_cmp++;
        if ({valid_out, data_out} !== {1'b1, 32'h22}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got valid=%b data=%h expected valid=1 data=22", valid_out, data_out);
        end
        reset = 1'b1; data_in = 32'h99;
        step();
        n_cmp++;
        if ({empty, valid_out, overflow} !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_state: got empty/valid/ovf %b expected 100", {empty, valid_out, overflow});
        end
        n_cmp++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_data: got %h expected 00000000", data_out);
        end
        reset = 1'b0; valid_in = 1'b0;
        step();
        n_cmp++;
        if ({empty, valid_out} !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_discard: got empty/valid %b expected 10", {empty, valid_out});
        end
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] exp;
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; data_in = 32'h200 + 32'(i);
            q.push_back(data_in);
            step();
        end
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 32'h300 + 32'(i);
            step();
            exp = q.pop_front();
            q.push_back(32'h300 + 32'(i));
            n_cmp++;
            if ({valid_out, data_out} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL b2b_rd[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, valid_out, data_out, exp);
            end
            n_cmp++;
            if ({full, empty, almost_full, almost_empty, overflow} !== 5'b00000) begin
                n_fail++;
                $display("FAIL b2b_flags[%0d]: got %b expected 00000", i, {full, empty, almost_full, almost_empty, overflow});
            end
        end
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = q.pop_front();
            n_cmp++;
            if ({valid_out, data_out} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL b2b_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, valid_out, data_out, exp);
            end
        end
        step();
        n_cmp++;
        if ({empty, valid_out} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_end: got empty/valid %b expected 10", {empty, valid_out});
        end
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; rd_en = 1'b0; data_in = '0;
        test_reset();
        test_basic();
        test_empty_read();
        test_idle();
        test_overflow();
        test_full_simul();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_phy_rx_fifo
`default_nettype wire

// File: doc/phy_rx_fifo.md
PHY_RX_FIFO -- requirements
Module: phy_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of a PHY receive word.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, minimum 4.
REQ-003 SHALL have parameter AF_THRESH, default 6; almost_full asserts at this occupancy or above.
REQ-004 SHALL have parameter AE_THRESH, default 2; almost_empty asserts at this occupancy or below.
REQ-005 SHALL have port clk_f, input, 1 bit: the single clock, i.e. the PHY word clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port data_in, input, DATA_W bits: word from the PHY receiver.
REQ-008 SHALL have port valid_in, input, 1 bit: data_in carries a word this cycle.
REQ-009 SHALL have port rd_en, input, 1 bit: pop request from the link layer.
REQ-010 SHALL have port data_out, output, DATA_W bits: popped word.
REQ-011 SHALL have port valid_out, output, 1 bit: data_out holds a popped word this cycle.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty, outputs, 1 bit each: occupancy flags.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, a non-idle word was dropped.
REQ-014 SHALL have port err_count, output, 8 bits, present only with PHY_RX_FIFO_ERR_CNT_EN: count of dropped words.

Function
REQ-015 SHALL write data_in at the edge where valid_in=1, data_in!=IDLE_WORD (32'hBCBCBCBC), and the write is allowed.
REQ-016 SHALL never store IDLE_WORD words; these are discarded silently with no flag change.
REQ-017 SHALL pop on an edge where rd_en=1 and empty=0; data_out/valid_out register the head word, so data_out is valid the cycle after the rd_en cycle.
REQ-018 SHALL drive valid_out=0 on any cycle following a non-popping cycle; data_out holds its last value.
REQ-019 SHALL have 2-cycle minimum write-to-output latency: write at edge N, pop at edge N+1, valid_out high after edge N+1.
REQ-020 SHALL ignore rd_en while empty=1, including a simultaneous write to an empty FIFO; no underflow flag.
REQ-021 SHALL accept a write while full=1 only if a pop occurs on the same edge; occupancy is then unchanged.
REQ-022 SHALL drop a non-idle valid word when full=1 and no pop occurs, set overflow and, with the macro, increment err_count.
REQ-023 SHALL keep occupancy unchanged when a write and a pop occur on the same edge with occupancy between 1 and DEPTH-1.
REQ-024 SHALL use write and read pointers that wrap modulo DEPTH, plus a $clog2(DEPTH)+1-bit occupancy count.
REQ-025 SHALL derive all flags combinationally from the registered count: full=(count==DEPTH), empty=(count==0).

Reset
REQ-026 SHALL, on reset=1 at an edge, clear the pointers, count, data_out, valid_out, overflow, and err_count; stored contents become don't-care.
REQ-027 SHALL, after reset, present empty=1, almost_empty=1, full=0, almost_full=0.
REQ-028 SHALL give reset priority over simultaneous write and pop; a word presented during reset is discarded.

Configuration
REQ-029 SHALL, with PHY_RX_FIFO_ERR_CNT_EN defined, provide err_count, saturating at 8'hFF.
REQ-030 SHALL, without PHY_RX_FIFO_ERR_CNT_EN, omit the err_count port and its register; all other behaviour is identical.

Structure
REQ-031 SHALL take IDLE_WORD, DATA_W, and DEPTH defaults from the shared PHY package/header, used by phy_tx and phy_rx.
REQ-032 SHALL place storage in one sub-module, phy_fifo_mem: a DEPTH x DATA_W array with synchronous write and asynchronous read.

Verification
REQ-033 SHALL check: write 32'h00000001..32'h00000003 on consecutive cycles, then rd_en for 3 cycles -> data_out 1,2,3, with valid_out high starting the cycle after the first rd_en.
REQ-034 SHALL check: valid_in with 32'hBCBCBCBC for 5 cycles -> empty stays 1, count 0, overflow 0.
REQ-035 SHALL check: 9 distinct writes with no reads, DEPTH=8 -> full=1 after the 8th; 9th dropped, overflow=1, err_count=1 (macro); reads return words 1..8.
REQ-036 SHALL check: full FIFO with simultaneous write 32'hA5A5A5A5 and rd_en -> full stays 1, no overflow, A5A5A5A5 is read last.
REQ-037 SHALL check: 4 words written, reset pulsed for 1 cycle mid-stream with rd_en=1 -> empty=1, valid_out=0, overflow=0 on the next cycle.
REQ-038 SHALL check: continuous write and read for 20 cycles -> pointers wrap, no loss, flags consistent.
